// File: rtl/led_out_port.sv
// LED output port: snoops processor stores to OUT_ADDR into a small FIFO and
// plays each queued byte on LedBar for HOLD_CYCLES cycles.
module led_out_port #(
    parameter logic [7:0] OUT_ADDR    = 8'hFF,
    parameter int         DEPTH       = 4,
    parameter int         HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       WRITE,
    input  logic [7:0] ADDR,
    input  logic [7:0] D,
    output logic [7:0] LedBar,
    output logic       EMPTY,
    output logic       FULL,
    output logic       DROP
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    led_q, led_d;
    logic          drop_q, drop_d;
    logic [7:0]    mem_q [DEPTH];

    logic empty_s;
    logic full_s;
    logic hit_s;
    logic push_s;
    logic pop_s;

    assign empty_s = (count_q == {CW{1'b0}});
    assign full_s  = (count_q == COUNT_FULL);
    assign hit_s   = WRITE && (ADDR == OUT_ADDR);

    // Display FSM: decides when the head byte is popped onto the LED bar.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        led_d   = led_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    led_d   = mem_q[rd_ptr_q];
                    hold_d  = HOLD_LOAD;
                    state_d = SHOW;
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                if (hold_q != {HW{1'b0}}) begin
                    hold_d = hold_q - HW'(1);
                end else if (!empty_s) begin
                    pop_s  = 1'b1;
                    led_d  = mem_q[rd_ptr_q];
                    hold_d = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a pop on the same edge frees the slot a full-FIFO push needs.
    always_comb begin
        push_s   = hit_s && (!full_s || pop_s);
        drop_d   = hit_s && !push_s;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            hold_q   <= {HW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            led_q    <= 8'h00;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            led_q    <= led_d;
            drop_q   <= drop_d;
        end
    end

    // FIFO storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= D;
        end
    end

    assign LedBar = led_q;
    assign EMPTY  = empty_s;
    assign FULL   = full_s;
    assign DROP   = drop_q;

endmodule

// File: tb/tb_led_out_port.sv
// Directed bench for led_out_port: HOLD_CYCLES=4 instance plus a HOLD_CYCLES=1 instance.
module tb_led_out_port;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       write_a = 1'b0;
    logic [7:0] addr_a = 8'h00;
    logic [7:0] d_a = 8'h00;
    logic [7:0] led_a;
    logic       empty_a, full_a, drop_a;
    logic       write_b = 1'b0;
    logic [7:0] addr_b = 8'h00;
    logic [7:0] d_b = 8'h00;
    logic [7:0] led_b;
    logic       empty_b, full_b, drop_b;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] led;
        logic       e;
        logic       f;
        logic       dr;
    } vec_t;

    vec_t vecs[$];

    led_out_port #(.OUT_ADDR(8'hFF), .DEPTH(4), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .WRITE(write_a), .ADDR(addr_a), .D(d_a),
        .LedBar(led_a), .EMPTY(empty_a), .FULL(full_a), .DROP(drop_a)
    );

    led_out_port #(.OUT_ADDR(8'hFF), .DEPTH(4), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .WRITE(write_b), .ADDR(addr_b), .D(d_b),
        .LedBar(led_b), .EMPTY(empty_b), .FULL(full_b), .DROP(drop_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm, input logic [7:0] led, input logic e,
                         input logic f, input logic dr);
        chk({nm, ".led"},   led_a,         led);
        chk({nm, ".empty"}, {7'd0, empty_a}, {7'd0, e});
        chk({nm, ".full"},  {7'd0, full_a},  {7'd0, f});
        chk({nm, ".drop"},  {7'd0, drop_a},  {7'd0, dr});
    endtask

    task automatic add(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] led, input logic e, input logic f, input logic dr);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.led = led; v.e = e; v.f = f; v.dr = dr;
        vecs.push_back(v);
    endtask

    // Drive inputs for the next edge, then sample 1 time unit after it.
    task automatic step_a(input logic w, input logic [7:0] a, input logic [7:0] d);
        write_a = w; addr_a = a; d_a = d;
        @(posedge clk);
        #1;
        write_a = 1'b0; addr_a = 8'h00; d_a = 8'h00;
    endtask

    // Mid-cycle reset pulse, held across two edges; returns mid-cycle.
    task automatic do_reset();
        #3 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
    endtask

    initial begin
        // Burst/overflow table: edges 1..26 after reset.
        add(1'b1, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 8'h04, 8'h01, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 8'h05, 8'h01, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'hFF, 8'h06, 8'h02, 1'b0, 1'b1, 1'b0);
        add(1'b1, 8'hFF, 8'h07, 8'h02, 1'b0, 1'b1, 1'b1);
        add(1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0);
        for (int i = 10; i <= 13; i++) add(1'b0, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
        for (int i = 14; i <= 17; i++) add(1'b0, 8'h00, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0);
        for (int i = 18; i <= 21; i++) add(1'b0, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
        for (int i = 22; i <= 26; i++) add(1'b0, 8'h00, 8'h00, 8'h06, 1'b1, 1'b0, 1'b0);

        // Power-on reset values.
        @(posedge clk);
        #3;
        chk_a("por", 8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Burst and overflow, then an IDLE check: next store shows one edge later.
        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].w, vecs[i].a, vecs[i].d);
            chk_a($sformatf("burst_e%0d", i + 1), vecs[i].led, vecs[i].e, vecs[i].f, vecs[i].dr);
        end
        step_a(1'b1, 8'hFF, 8'h77);
        chk_a("post_burst_push", 8'h06, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 8'h00);
        chk_a("post_burst_show", 8'h77, 1'b1, 1'b0, 1'b0);

        // Single store, then address filter.
        do_reset();
        step_a(1'b1, 8'hFF, 8'h0D);
        chk_a("single_accept", 8'h00, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 8'h00);
        chk_a("single_show", 8'h0D, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step_a(1'b0, 8'h00, 8'h00);
        chk_a("single_hold", 8'h0D, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 8'h6A, 8'h55);
            chk_a("filter_addr", 8'h0D, 1'b1, 1'b0, 1'b0);
            step_a(1'b0, 8'hFF, 8'h55);
            chk_a("filter_read", 8'h0D, 1'b1, 1'b0, 1'b0);
        end
        step_a(1'b1, 8'hFF, 8'h42);
        step_a(1'b0, 8'h00, 8'h00);
        chk_a("after_filter", 8'h42, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of the burst.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k <= 7) step_a(1'b1, 8'hFF, 8'(k));
            else        step_a(1'b0, 8'h00, 8'h00);
        end
        chk_a("pre_midreset", 8'h03, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk_a("midreset_async", 8'h00, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step_a(1'b0, 8'h00, 8'h00);
            chk("midreset_quiet.led", led_a, 8'h00);
            chk("midreset_quiet.empty", {7'd0, empty_a}, 8'h01);
        end
        step_a(1'b1, 8'hFF, 8'h3C);
        chk_a("midreset_new_accept", 8'h00, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 8'h00);
        chk_a("midreset_new_show", 8'h3C, 1'b1, 1'b0, 1'b0);

        // HOLD_CYCLES=1 instance.
        do_reset();
        write_b = 1'b1; addr_b = 8'hFF; d_b = 8'hA5;
        @(posedge clk); #1;
        chk("h1_e1.led", led_b, 8'h00);
        d_b = 8'h5A;
        @(posedge clk); #1;
        write_b = 1'b0; addr_b = 8'h00; d_b = 8'h00;
        chk("h1_e2.led", led_b, 8'hA5);
        chk("h1_e2.empty", {7'd0, empty_b}, 8'h00);
        @(posedge clk); #1;
        chk("h1_e3.led", led_b, 8'h5A);
        chk("h1_e3.empty", {7'd0, empty_b}, 8'h01);
        write_b = 1'b1; addr_b = 8'hFF; d_b = 8'h11;
        @(posedge clk); #1;
        write_b = 1'b0; addr_b = 8'h00; d_b = 8'h00;
        chk("h1_e4.led", led_b, 8'h5A);
        @(posedge clk); #1;
        chk("h1_e5.led", led_b, 8'h11);
        chk("h1_e5.drop", {7'd0, drop_b}, 8'h00);
        chk("h1_e5.full", {7'd0, full_b}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
